metronome_sequencer: RTL and testbench
======================================

Name: metronome_sequencer

Overview:
Top-level tempo controller for the metronome. It turns two raw push-buttons into a saturating BPM setting and schedules beats from a phase accumulator, so the average period is exactly CLK_FREQ*60/bpm with no divider. It also counts beats within a bar, drives the LED beat pattern, and gates a square-wave tone onto the speaker pin for a fixed beep length per beat.

Parameters:
CLK_FREQ, 24000000, sys_clk frequency in Hz
BPM_MIN, 40, lowest selectable tempo
BPM_MAX, 240, highest selectable tempo (must be <=255)
BPM_DEFAULT, 90, tempo after reset
BPM_STEP, 5, increment/decrement per button press
BEATS_PER_BAR, 4, beats per bar, legal range 2..8
BEEP_CYCLES, 1440000, beep length in clocks (60 ms)
DEBOUNCE_CYCLES, 240000, input stable time in clocks (10 ms)
TONE_HALF, 12000, normal tone half-period in clocks (1 kHz)
ACCENT_HALF, 6000, accent tone half-period in clocks (2 kHz)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset
btn_up_n  in  1  raw tempo-up button, active-low, asynchronous
btn_down_n  in  1  raw tempo-down button, active-low, asynchronous
speaker  out  1  buzzer drive, idle high
led  out  3  beat indicator, active-low
beat_strobe  out  1  one-cycle pulse per beat
bpm  out  8  current tempo

Behaviour:
- Clock and reset: sys_clk is the only clock. sys_rst_n is asynchronous, active-low.
- Reset values: speaker=1, led=3'b111, beat_strobe=0, bpm=BPM_DEFAULT. Accumulator, beat_idx, beep counter and tone counter all 0. Debounce state is "released".
- Input conditioning: each button passes through a 2-FF synchronizer, then a debounce counter. A new level is accepted only after DEBOUNCE_CYCLES consecutive identical samples. A press event is a single one-cycle pulse on the debounced 1->0 transition. Holding a button gives no auto-repeat.
- Tempo update, registered one cycle after the press event:
  - up: bpm = min(bpm+BPM_STEP, BPM_MAX)
  - down: bpm = max(bpm-BPM_STEP, BPM_MIN)
  - up and down events in the same cycle: both ignored.
  - The accumulator is not cleared on a tempo change; the new rate applies from the next cycle.
- Beat scheduler: 32-bit accumulator, LIMIT = CLK_FREQ*60.
  - Each cycle: if acc+bpm >= LIMIT, then acc <= acc+bpm-LIMIT and a beat fires; otherwise acc <= acc+bpm.
  - The first beat after reset occurs on the cycle where the sum first reaches LIMIT, i.e. after ceil(LIMIT/bpm) cycles.
- On a beat, in the same registered cycle:
  - beat_strobe=1 for exactly one cycle.
  - beat_idx is sampled for this beat, then incremented, wrapping at BEATS_PER_BAR-1 -> 0.
  - led updates from the sampled index: 0->3'b110, 1->3'b101, 2->3'b011, >=3->3'b000. led holds until the next beat.
  - beep counter loads BEEP_CYCLES; tone counter clears; speaker goes 0.
  - Tone half-period is ACCENT_HALF when the sampled index==0, else TONE_HALF.
- Beep state machine: states IDLE and BEEP.
  - BEEP: beep counter decrements each cycle. speaker toggles each time the tone counter reaches half-period-1, then the tone counter restarts. When the beep counter reaches 0, go to IDLE with speaker=1.
  - A beat arriving while in BEEP restarts the beep: counter reloads, phase resets, speaker=0.
  - Designers keep BEEP_CYCLES below the beat period at BPM_MAX.
- Reset mid-beep: speaker returns to 1 immediately (asynchronous) and beat_idx returns to 0.

Optional Feature:
Macro ACCENT_EN.
- Defined: beat 0 of each bar uses ACCENT_HALF, giving an audible downbeat.
- Not defined: every beat uses TONE_HALF; ACCENT_HALF is unused. LED pattern and beat_strobe are unchanged.

Test Plan:
Test parameters for all scenarios: CLK_FREQ=100, BPM_DEFAULT=60, DEBOUNCE_CYCLES=4, BEEP_CYCLES=20, TONE_HALF=2, ACCENT_HALF=1, BEATS_PER_BAR=4 (LIMIT=6000).
1. Release reset, no buttons -> beat_strobe pulses at cycles 100, 200, 300, 400, 500 after reset. led sequence 110, 101, 011, 000, 110. bpm stays 60.
2. Observe speaker after the beat at cycle 200 (index 1) -> low 2, high 2, repeating for 20 cycles, then steady 1. With ACCENT_EN defined, the beat at cycle 100 toggles every cycle; without it, that beat matches the 2/2 pattern.
3. Pulse btn_up_n low for 3 cycles -> no bpm change. Hold low for 10 cycles -> bpm 60->65 exactly once. Press 40 more times -> bpm saturates at 240.
4. Press btn_down_n repeatedly from 60 -> 55, 50, 45, 40, then stays 40. Beat spacing at 40 bpm is 150 cycles.
5. Press up and down so their press events coincide -> bpm unchanged, no spurious beat.
6. Assert sys_rst_n low 5 cycles into a beep -> speaker=1 and led=111 immediately. After release, the first beat arrives 100 cycles later, with beat_idx=0 (led 110).

Source files
------------

// File: rtl/metronome_sequencer.sv
// Metronome tempo controller: debounced tempo buttons, phase-accumulator beat
// scheduler, bar position / LED pattern, and a gated square-wave beep per beat.
// Optional feature: define ACCENT_EN to play the downbeat (beat 0 of each bar)
// with the higher-pitched ACCENT_HALF tone.
module metronome_sequencer #(
  parameter int unsigned CLK_FREQ        = 24000000,
  parameter int unsigned BPM_MIN         = 40,
  parameter int unsigned BPM_MAX         = 240,
  parameter int unsigned BPM_DEFAULT     = 90,
  parameter int unsigned BPM_STEP        = 5,
  parameter int unsigned BEATS_PER_BAR   = 4,
  parameter int unsigned BEEP_CYCLES     = 1440000,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned TONE_HALF       = 12000,
  parameter int unsigned ACCENT_HALF     = 6000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  output logic       speaker,
  output logic [2:0] led,
  output logic       beat_strobe,
  output logic [7:0] bpm
);

  localparam logic [32:0] LIMIT = 33'(CLK_FREQ) * 33'd60;

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int unsigned BEEP_W  = $clog2(BEEP_CYCLES + 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES);
  localparam logic [BEEP_W-1:0] BEEP_ONE  = BEEP_W'(1);

  localparam int unsigned HALF_MAX = (TONE_HALF > ACCENT_HALF) ? TONE_HALF : ACCENT_HALF;
  localparam int unsigned TONE_W   = $clog2(HALF_MAX + 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
`ifdef ACCENT_EN
  localparam logic [TONE_W-1:0] ACCENT_LAST = TONE_W'(ACCENT_HALF - 1);
`endif

  localparam logic [2:0] IDX_LAST = 3'(BEATS_PER_BAR - 1);

  typedef enum logic [0:0] {StIdle, StBeep} beep_state_e;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            db_level_q, db_level_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]            press_q, press_d;

  logic [7:0]            bpm_q, bpm_d;
  logic [8:0]            bpm_up_sum;

  logic [31:0]           acc_q, acc_d;
  logic [32:0]           acc_sum;
  logic                  fire;

  logic                  beat_strobe_q;
  logic [2:0]            beat_idx_q;
  logic [2:0]            led_q, led_pattern;
  logic [TONE_W-1:0]     half_last_q, beat_half_last;

  beep_state_e           state_q, state_d;
  logic [BEEP_W-1:0]     beep_cnt_q, beep_cnt_d;
  logic [TONE_W-1:0]     tone_cnt_q, tone_cnt_d;
  logic                  speaker_q, speaker_d;

  assign btn_raw = {btn_down_n, btn_up_n};

  // Two-flop synchronizers; reset to the released level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: adopt a new level once it has been sampled DEBOUNCE_CYCLES times in a row.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_level_d[i] = sync2_q[i];
          press_d[i]    = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state and one-cycle press events.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_level_q <= 2'b11;
      db_cnt_q   <= '0;
      press_q    <= '0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
    end
  end

  assign bpm_up_sum = {1'b0, bpm_q} + 9'(BPM_STEP);

  // Saturating tempo step; simultaneous up and down cancel out.
  always_comb begin
    bpm_d = bpm_q;
    if (press_q[0] && !press_q[1]) begin
      bpm_d = (bpm_up_sum > 9'(BPM_MAX)) ? 8'(BPM_MAX) : bpm_up_sum[7:0];
    end else if (press_q[1] && !press_q[0]) begin
      bpm_d = (bpm_q < 8'(BPM_MIN + BPM_STEP)) ? 8'(BPM_MIN) : bpm_q - 8'(BPM_STEP);
    end
  end

  // Beat scheduler: add bpm every cycle, fire and wrap once the sum reaches CLK_FREQ*60.
  always_comb begin
    acc_sum = {1'b0, acc_q} + 33'(bpm_q);
    fire    = (acc_sum >= LIMIT);
    acc_d   = fire ? 32'(acc_sum - LIMIT) : acc_sum[31:0];
  end

  // Tempo and phase accumulator registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bpm_q <= 8'(BPM_DEFAULT);
      acc_q <= '0;
    end else begin
      bpm_q <= bpm_d;
      acc_q <= acc_d;
    end
  end

  // LED pattern and tone pitch for the beat about to fire, from the current bar index.
  always_comb begin
    case (beat_idx_q)
      3'd0:    led_pattern = 3'b110;
      3'd1:    led_pattern = 3'b101;
      3'd2:    led_pattern = 3'b011;
      default: led_pattern = 3'b000;
    endcase
`ifdef ACCENT_EN
    beat_half_last = (beat_idx_q == 3'd0) ? ACCENT_LAST : TONE_LAST;
`else
    beat_half_last = TONE_LAST;
`endif
  end

  // Beat bookkeeping: strobe, bar position, LED hold and tone pitch latch.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beat_strobe_q <= 1'b0;
      beat_idx_q    <= '0;
      led_q         <= 3'b111;
      half_last_q   <= TONE_LAST;
    end else begin
      beat_strobe_q <= fire;
      if (fire) begin
        beat_idx_q  <= (beat_idx_q == IDX_LAST) ? 3'd0 : beat_idx_q + 3'd1;
        led_q       <= led_pattern;
        half_last_q <= beat_half_last;
      end
    end
  end

  // Beep FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Beep FSM next state: any beat (re)starts the beep, it ends when the counter runs out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fire) state_d = StBeep;
      StBeep:  if (!fire && beep_cnt_q == BEEP_ONE) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Beep FSM outputs: beep length countdown and tone square wave, starting low.
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    tone_cnt_d = tone_cnt_q;
    speaker_d  = speaker_q;
    if (fire) begin
      beep_cnt_d = BEEP_LOAD;
      tone_cnt_d = '0;
      speaker_d  = 1'b0;
    end else if (state_q == StBeep) begin
      beep_cnt_d = beep_cnt_q - 1'b1;
      if (beep_cnt_q == BEEP_ONE) begin
        tone_cnt_d = '0;
        speaker_d  = 1'b1;
      end else if (tone_cnt_q == half_last_q) begin
        tone_cnt_d = '0;
        speaker_d  = ~speaker_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
      end
    end
  end

  // Beep datapath registers; speaker idles high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beep_cnt_q <= '0;
      tone_cnt_q <= '0;
      speaker_q  <= 1'b1;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      speaker_q  <= speaker_d;
    end
  end

  assign speaker     = speaker_q;
  assign led         = led_q;
  assign beat_strobe = beat_strobe_q;
  assign bpm         = bpm_q;

endmodule

// File: tb/tb_metronome_sequencer.sv
// Self-checking bench for metronome_sequencer with small test parameters
// (LIMIT = 100*60 = 6000). A behavioural model tracks debounced button levels
// as sample windows, beat phase as plain arithmetic and the speaker as a
// function of time since the last beat.
module tb_metronome_sequencer;

  localparam int CLKF    = 100;
  localparam int BPM_MIN = 40;
  localparam int BPM_MAX = 240;
  localparam int BPM_DEF = 60;
  localparam int STEP    = 5;
  localparam int BPB     = 4;
  localparam int BEEP    = 20;
  localparam int DB      = 4;
  localparam int TONE_H  = 2;
  localparam int ACC_H   = 1;
  localparam int LIMIT   = CLKF * 60;
`ifdef ACCENT_EN
  localparam bit ACCENT = 1'b1;
`else
  localparam bit ACCENT = 1'b0;
`endif

  logic       sys_clk    = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic       btn_up_n   = 1'b1;
  logic       btn_down_n = 1'b1;
  logic       speaker;
  logic [2:0] led;
  logic       beat_strobe;
  logic [7:0] bpm;

  int n_checks = 0;
  int n_errors = 0;

  metronome_sequencer #(
    .CLK_FREQ       (CLKF),
    .BPM_MIN        (BPM_MIN),
    .BPM_MAX        (BPM_MAX),
    .BPM_DEFAULT    (BPM_DEF),
    .BPM_STEP       (STEP),
    .BEATS_PER_BAR  (BPB),
    .BEEP_CYCLES    (BEEP),
    .DEBOUNCE_CYCLES(DB),
    .TONE_HALF      (TONE_H),
    .ACCENT_HALF    (ACC_H)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .btn_up_n   (btn_up_n),
    .btn_down_n (btn_down_n),
    .speaker    (speaker),
    .led        (led),
    .beat_strobe(beat_strobe),
    .bpm        (bpm)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [2:0] led_of(int idx);
    case (idx)
      0:       return 3'b110;
      1:       return 3'b101;
      2:       return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Raw button history: bit 0 newest. The debouncer sees samples two clocks late.
  logic [DB+1:0] m_up_sh, m_dn_sh;
  logic          m_up_lvl, m_dn_lvl, m_up_ev, m_dn_ev;
  int            m_bpm, m_phase, m_beats, m_since, m_half;
  logic          m_strobe, m_any;
  logic [2:0]    m_led;

  wire [DB+1:0] up_nx   = {m_up_sh[DB:0], btn_up_n};
  wire [DB+1:0] dn_nx   = {m_dn_sh[DB:0], btn_down_n};
  wire          up_flip = (up_nx[DB+1:2] == {DB{~m_up_lvl}});
  wire          dn_flip = (dn_nx[DB+1:2] == {DB{~m_dn_lvl}});
  wire          fire_nx = (m_phase + m_bpm >= LIMIT);
  wire          m_spk   = (m_any && m_since < BEEP) ? (((m_since / m_half) % 2) == 1) : 1'b1;

  int bpm_nx;
  always_comb begin
    bpm_nx = m_bpm;
    if (m_up_ev && !m_dn_ev) bpm_nx = (m_bpm + STEP > BPM_MAX) ? BPM_MAX : m_bpm + STEP;
    else if (m_dn_ev && !m_up_ev) bpm_nx = (m_bpm - STEP < BPM_MIN) ? BPM_MIN : m_bpm - STEP;
  end

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_up_sh  <= '1;
      m_dn_sh  <= '1;
      m_up_lvl <= 1'b1;
      m_dn_lvl <= 1'b1;
      m_up_ev  <= 1'b0;
      m_dn_ev  <= 1'b0;
      m_bpm    <= BPM_DEF;
      m_phase  <= 0;
      m_beats  <= 0;
      m_since  <= 0;
      m_half   <= TONE_H;
      m_strobe <= 1'b0;
      m_any    <= 1'b0;
      m_led    <= 3'b111;
    end else begin
      m_up_sh  <= up_nx;
      m_dn_sh  <= dn_nx;
      m_up_lvl <= up_flip ? ~m_up_lvl : m_up_lvl;
      m_dn_lvl <= dn_flip ? ~m_dn_lvl : m_dn_lvl;
      m_up_ev  <= up_flip && m_up_lvl;
      m_dn_ev  <= dn_flip && m_dn_lvl;
      m_bpm    <= bpm_nx;
      m_phase  <= fire_nx ? m_phase + m_bpm - LIMIT : m_phase + m_bpm;
      m_strobe <= fire_nx;
      if (fire_nx) begin
        m_led   <= led_of(m_beats % BPB);
        m_beats <= m_beats + 1;
        m_since <= 0;
        m_any   <= 1'b1;
        m_half  <= (ACCENT && (m_beats % BPB == 0)) ? ACC_H : TONE_H;
      end else if (m_since < 100000) begin
        m_since <= m_since + 1;
      end
    end
  end

  // Reset held across a few clocks, released on a falling edge so the next
  // rising edge is cycle 1.
  task automatic do_reset();
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    sys_rst_n  = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    sys_rst_n  = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_checks++;
    if (speaker !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_speaker got=%b want=1", speaker);
    end
    n_checks++;
    if (led !== 3'b111) begin
      n_errors++;
      $display("FAIL reset_led got=%b want=111", led);
    end
    n_checks++;
    if (beat_strobe !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_strobe got=%b want=0", beat_strobe);
    end
    n_checks++;
    if (bpm !== 8'(BPM_DEF)) begin
      n_errors++;
      $display("FAIL reset_bpm got=%0d want=%0d", bpm, BPM_DEF);
    end
  endtask

  // Free-running beats at 60 bpm, LED sequence and beep waveforms.
  task automatic test_beats();
    int nb;
    int base;
    int h;
    int k;
    logic [2:0] exp_led;
    logic exp_spk;
    do_reset();
    for (int c = 1; c <= 520; c++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({beat_strobe, led, speaker, bpm} !== {m_strobe, m_led, m_spk, 8'(m_bpm)}) begin
        n_errors++;
        $display("FAIL beats_model c=%0d got s=%b l=%b spk=%b bpm=%0d want s=%b l=%b spk=%b bpm=%0d",
                 c, beat_strobe, led, speaker, bpm, m_strobe, m_led, m_spk, m_bpm);
      end
      nb = c / 100;
      exp_led = (nb == 0) ? 3'b111 : led_of((nb - 1) % BPB);
      n_checks++;
      if (beat_strobe !== (c % 100 == 0) || led !== exp_led) begin
        n_errors++;
        $display("FAIL beats_timing c=%0d got s=%b l=%b want s=%b l=%b",
                 c, beat_strobe, led, (c % 100 == 0), exp_led);
      end
      if ((c >= 100 && c < 124) || (c >= 200 && c < 224)) begin
        base = (c >= 200) ? 200 : 100;
        h = (base == 100 && ACCENT) ? ACC_H : TONE_H;
        k = c - base;
        exp_spk = (k < BEEP) ? (((k / h) % 2) == 1) : 1'b1;
        n_checks++;
        if (speaker !== exp_spk) begin
          n_errors++;
          $display("FAIL beep_wave c=%0d got=%b want=%b", c, speaker, exp_spk);
        end
      end
    end
    n_checks++;
    if (bpm !== 8'd60) begin
      n_errors++;
      $display("FAIL beats_bpm got=%0d want=60", bpm);
    end
  endtask

  // Short glitch is ignored, a long press steps once, repeated presses saturate.
  task automatic test_tempo_up();
    int hold;
    int gap;
    do_reset();
    for (int p = 0; p < 42; p++) begin
      hold = (p == 0) ? 3 : (p == 1) ? 10 : $urandom_range(5, 12);
      gap  = $urandom_range(6, 12);
      for (int k = 0; k < hold + gap; k++) begin
        btn_up_n = (k < hold) ? 1'b0 : 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if ({beat_strobe, led, speaker, bpm} !== {m_strobe, m_led, m_spk, 8'(m_bpm)}) begin
          n_errors++;
          $display("FAIL up_model p=%0d got s=%b l=%b spk=%b bpm=%0d want s=%b l=%b spk=%b bpm=%0d",
                   p, beat_strobe, led, speaker, bpm, m_strobe, m_led, m_spk, m_bpm);
        end
      end
      if (p == 0 || p == 1) begin
        n_checks++;
        if (bpm !== ((p == 0) ? 8'd60 : 8'd65)) begin
          n_errors++;
          $display("FAIL up_step p=%0d got=%0d want=%0d", p, bpm, (p == 0) ? 60 : 65);
        end
      end
    end
    n_checks++;
    if (bpm !== 8'(BPM_MAX)) begin
      n_errors++;
      $display("FAIL up_saturate got=%0d want=%0d", bpm, BPM_MAX);
    end
  endtask

  // Stepping down saturates at BPM_MIN; then beat spacing is 6000/40.
  task automatic test_tempo_down();
    int want;
    int t;
    bit seen;
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 18; k++) begin
        btn_down_n = (k < 8) ? 1'b0 : 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if ({beat_strobe, led, speaker, bpm} !== {m_strobe, m_led, m_spk, 8'(m_bpm)}) begin
          n_errors++;
          $display("FAIL down_model p=%0d got s=%b l=%b spk=%b bpm=%0d want s=%b l=%b spk=%b bpm=%0d",
                   p, beat_strobe, led, speaker, bpm, m_strobe, m_led, m_spk, m_bpm);
        end
      end
      want = (60 - STEP * (p + 1) < BPM_MIN) ? BPM_MIN : 60 - STEP * (p + 1);
      n_checks++;
      if (bpm !== 8'(want)) begin
        n_errors++;
        $display("FAIL down_step p=%0d got=%0d want=%0d", p, bpm, want);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge sys_clk);
      seen = beat_strobe;
    end
    t = 0;
    if (seen) begin
      seen = 1'b0;
      for (int c = 1; c <= 400 && !seen; c++) begin
        @(negedge sys_clk);
        if (beat_strobe) begin
          seen = 1'b1;
          t = c;
        end
      end
    end
    n_checks++;
    if (t != 150) begin
      n_errors++;
      $display("FAIL down_spacing got=%0d want=150", t);
    end
  endtask

  // Coinciding up/down events cancel; a final trial uses random offsets.
  task automatic test_both_buttons();
    int hold;
    int off;
    do_reset();
    for (int tr = 0; tr < 4; tr++) begin
      hold = $urandom_range(5, 12);
      off  = (tr == 3) ? $urandom_range(0, 3) : 0;
      for (int k = 0; k < hold + off + 12; k++) begin
        btn_up_n   = (k < hold) ? 1'b0 : 1'b1;
        btn_down_n = (k >= off && k < hold + off) ? 1'b0 : 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if ({beat_strobe, led, speaker, bpm} !== {m_strobe, m_led, m_spk, 8'(m_bpm)}) begin
          n_errors++;
          $display("FAIL both_model tr=%0d got s=%b l=%b spk=%b bpm=%0d want s=%b l=%b spk=%b bpm=%0d",
                   tr, beat_strobe, led, speaker, bpm, m_strobe, m_led, m_spk, m_bpm);
        end
      end
      if (tr < 3) begin
        n_checks++;
        if (bpm !== 8'd60) begin
          n_errors++;
          $display("FAIL both_cancel tr=%0d got=%0d want=60", tr, bpm);
        end
      end
    end
  endtask

  // Random button activity on both inputs against the model.
  task automatic test_random();
    int run_up;
    int run_dn;
    run_up = 0;
    run_dn = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (run_up == 0) begin
        btn_up_n = $urandom_range(0, 1) == 1;
        run_up = $urandom_range(1, 12);
      end
      if (run_dn == 0) begin
        btn_down_n = $urandom_range(0, 1) == 1;
        run_dn = $urandom_range(1, 12);
      end
      run_up--;
      run_dn--;
      @(negedge sys_clk);
      n_checks++;
      if ({beat_strobe, led, speaker, bpm} !== {m_strobe, m_led, m_spk, 8'(m_bpm)}) begin
        n_errors++;
        $display("FAIL random_model c=%0d got s=%b l=%b spk=%b bpm=%0d want s=%b l=%b spk=%b bpm=%0d",
                 c, beat_strobe, led, speaker, bpm, m_strobe, m_led, m_spk, m_bpm);
      end
    end
  endtask

  // Reset during a beep forces the speaker high at once and restarts the bar.
  task automatic test_reset_mid_beep();
    bit seen;
    do_reset();
    for (int c = 1; c <= 104; c++) @(negedge sys_clk);
    n_checks++;
    if (speaker !== 1'b0) begin
      n_errors++;
      $display("FAIL midbeep_pre got=%b want=0", speaker);
    end
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (speaker !== 1'b1 || led !== 3'b111 || beat_strobe !== 1'b0) begin
      n_errors++;
      $display("FAIL midbeep_async got spk=%b led=%b s=%b want spk=1 led=111 s=0",
               speaker, led, beat_strobe);
    end
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge sys_clk);
      if (beat_strobe) seen = 1'b1;
      if (c < 100) begin
        n_checks++;
        if (beat_strobe !== 1'b0) begin
          n_errors++;
          $display("FAIL midbeep_early c=%0d got=1 want=0", c);
        end
      end
    end
    n_checks++;
    if (!seen || led !== 3'b110) begin
      n_errors++;
      $display("FAIL midbeep_first got strobe=%b led=%b want strobe=1 led=110", seen, led);
    end
  endtask

  initial begin
    test_reset();
    test_beats();
    test_tempo_up();
    test_tempo_down();
    test_both_buttons();
    test_random();
    test_reset_mid_beep();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
